// File: rtl/adc_scan_controller.sv
// adc_scan_controller
//   Sequences an external ADC conversion engine from the I2C command byte,
//   scanning up to six channels per pass in single-shot or continuous (auto)
//   mode, and keeps per-channel results as upper/lower byte pairs.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   adc_cmd_in[7:0]   [0] START, [1] AUTO, [7:2] channel enable mask (ch0..ch5)
//   status_out[7:0]   [7] busy, [6] timeout error (sticky), [5] auto active,
//                     [4:2] last channel converted, [1:0] pass count mod 4
//   adc_req           one-cycle conversion request pulse
//   adc_chan[2:0]     channel of the current request
//   adc_valid         one-cycle pulse qualifying adc_data
//   adc_data          conversion result (DATA_W bits)
//   chN_upper_out     result bits [DATA_W-1:8] of channel N, zero-extended
//   chN_lower_out     result bits [7:0] of channel N
//   scan_done         one-cycle pulse when a pass completes
module adc_scan_controller #(
  parameter int DATA_W         = 12,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int AUTO_GAP       = 50000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        adc_cmd_in,
  output logic [7:0]        status_out,
  output logic              adc_req,
  output logic [2:0]        adc_chan,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic [7:0]        ch0_upper_out,
  output logic [7:0]        ch0_lower_out,
  output logic [7:0]        ch1_upper_out,
  output logic [7:0]        ch1_lower_out,
  output logic [7:0]        ch2_upper_out,
  output logic [7:0]        ch2_lower_out,
  output logic [7:0]        ch3_upper_out,
  output logic [7:0]        ch3_lower_out,
  output logic [7:0]        ch4_upper_out,
  output logic [7:0]        ch4_lower_out,
  output logic [7:0]        ch5_upper_out,
  output logic [7:0]        ch5_lower_out,
  output logic              scan_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_REQ,
    ST_WAIT,
    ST_STORE,
    ST_GAP
  } state_t;

  // One counter serves both the conversion timeout and the auto-mode gap,
  // so it is sized for the larger of the two.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > AUTO_GAP) ? TIMEOUT_CYCLES : AUTO_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);

  state_t             state_q, state_d;
  // Only START and AUTO of the previous command are needed (edge detect and
  // status), so the mask bits are not kept here.
  logic [1:0]         cmd_q, cmd_d;
  logic [5:0]         mask_q, mask_d;
  logic [5:0]         done_q, done_d;
  logic               err_q, err_d;
  logic [1:0]         pass_q, pass_d;
  logic [2:0]         last_q, last_d;
  logic [2:0]         chan_q, chan_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               req_q, req_d;
  logic               sdone_q, sdone_d;
  logic [7:0]         upper_q [6];
  logic [7:0]         upper_d [6];
  logic [7:0]         lower_q [6];
  logic [7:0]         lower_d [6];

  logic               start_evt;
  logic [5:0]         pending;
  logic [2:0]         next_chan;
  logic               found;

  assign start_evt = adc_cmd_in[0] & ~cmd_q[0];

  // Lowest-numbered enabled channel not yet handled in this pass; scanning
  // downward lets the lowest hit overwrite any higher one.
  always_comb begin
    pending   = mask_q & ~done_q;
    next_chan = '0;
    found     = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      if (pending[i]) begin
        next_chan = 3'(i);
        found     = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cmd_d   = adc_cmd_in[1:0];
    mask_d  = mask_q;
    done_d  = done_q;
    err_d   = err_q;
    pass_d  = pass_q;
    last_d  = last_q;
    chan_d  = chan_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    req_d   = 1'b0;
    sdone_d = 1'b0;
    upper_d = upper_q;
    lower_d = lower_q;

    case (state_q)
      ST_IDLE: begin
        if (start_evt || adc_cmd_in[1]) begin
          mask_d  = adc_cmd_in[7:2];
          done_d  = '0;
          err_d   = 1'b0;
          state_d = ST_SELECT;
        end
      end

      ST_SELECT: begin
        if (found) begin
          chan_d  = next_chan;
          state_d = ST_REQ;
        end else begin
          sdone_d = 1'b1;
          pass_d  = pass_q + 2'd1;
          // AUTO is sampled live here so clearing it mid-pass ends after
          // the current pass.
          if (adc_cmd_in[1]) begin
            cnt_d   = '0;
            state_d = ST_GAP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      // The request pulse is registered, so it appears on adc_req in the
      // first WAIT cycle.
      ST_REQ: begin
        req_d   = 1'b1;
        cnt_d   = '0;
        state_d = ST_WAIT;
      end

      ST_WAIT: begin
        if (adc_valid) begin
          data_d  = adc_data;
          state_d = ST_STORE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          // Abandon this channel: flag the error and skip it, keeping its
          // previous result.
          err_d          = 1'b1;
          done_d[chan_q] = 1'b1;
          state_d        = ST_SELECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_STORE: begin
        upper_d[chan_q] = 8'(data_q >> 8);
        lower_d[chan_q] = data_q[7:0];
        done_d[chan_q]  = 1'b1;
        last_d          = chan_q;
        state_d         = ST_SELECT;
      end

      ST_GAP: begin
        if (!adc_cmd_in[1]) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(AUTO_GAP - 1)) begin
          mask_d  = adc_cmd_in[7:2];
          done_d  = '0;
          state_d = ST_SELECT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      mask_q  <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      pass_q  <= '0;
      last_q  <= '0;
      chan_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      req_q   <= 1'b0;
      sdone_q <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        upper_q[i] <= '0;
        lower_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      last_q  <= last_d;
      chan_q  <= chan_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      req_q   <= req_d;
      sdone_q <= sdone_d;
      for (int i = 0; i < 6; i++) begin
        upper_q[i] <= upper_d[i];
        lower_q[i] <= lower_d[i];
      end
    end
  end

  logic busy;
  logic auto_act;

  assign busy     = (state_q != ST_IDLE) && (state_q != ST_GAP);
  assign auto_act = cmd_q[1] && (state_q != ST_IDLE);

  assign status_out = {busy, err_q, auto_act, last_q, pass_q};
  assign adc_req    = req_q;
  assign adc_chan   = chan_q;
  assign scan_done  = sdone_q;

  assign ch0_upper_out = upper_q[0];
  assign ch0_lower_out = lower_q[0];
  assign ch1_upper_out = upper_q[1];
  assign ch1_lower_out = lower_q[1];
  assign ch2_upper_out = upper_q[2];
  assign ch2_lower_out = lower_q[2];
  assign ch3_upper_out = upper_q[3];
  assign ch3_lower_out = lower_q[3];
  assign ch4_upper_out = upper_q[4];
  assign ch4_lower_out = lower_q[4];
  assign ch5_upper_out = upper_q[5];
  assign ch5_lower_out = lower_q[5];

endmodule

// File: tb/tb_adc_scan_controller.sv
// tb_adc_scan_controller
//   Directed testbench for adc_scan_controller. Inputs are driven and outputs
//   sampled on the falling clock edge; the DUT acts on the rising edge.
module tb_adc_scan_controller;

  localparam int DATA_W = 12;
  localparam int TMO    = 1024;
  localparam int GAP    = 20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        adc_cmd_in;
  logic [7:0]        status_out;
  logic              adc_req;
  logic [2:0]        adc_chan;
  logic              adc_valid;
  logic [DATA_W-1:0] adc_data;
  logic [7:0]        up_o [6];
  logic [7:0]        lo_o [6];
  logic              scan_done;

  int checks = 0;
  int passed = 0;
  int req_total = 0;

  adc_scan_controller #(
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO),
    .AUTO_GAP(GAP)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .adc_cmd_in(adc_cmd_in),
    .status_out(status_out),
    .adc_req(adc_req),
    .adc_chan(adc_chan),
    .adc_valid(adc_valid),
    .adc_data(adc_data),
    .ch0_upper_out(up_o[0]),
    .ch0_lower_out(lo_o[0]),
    .ch1_upper_out(up_o[1]),
    .ch1_lower_out(lo_o[1]),
    .ch2_upper_out(up_o[2]),
    .ch2_lower_out(lo_o[2]),
    .ch3_upper_out(up_o[3]),
    .ch3_lower_out(lo_o[3]),
    .ch4_upper_out(up_o[4]),
    .ch4_lower_out(lo_o[4]),
    .ch5_upper_out(up_o[5]),
    .ch5_lower_out(lo_o[5]),
    .scan_done(scan_done)
  );

  always #5 clk = ~clk;

  // Running count of request pulses; tests compare deltas over quiet windows.
  always @(negedge clk) begin
    if (adc_req === 1'b1) req_total++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_req(input int max, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (adc_req === 1'b1) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max, output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (scan_done === 1'b1) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic respond(input logic [DATA_W-1:0] d);
    adc_valid = 1'b1;
    adc_data  = d;
    @(negedge clk);
    adc_valid = 1'b0;
    adc_data  = '0;
  endtask

  function automatic logic any_result_nonzero();
    logic nz;
    nz = 1'b0;
    for (int i = 0; i < 6; i++) nz = nz | (|up_o[i]) | (|lo_o[i]);
    return nz;
  endfunction

  task automatic test_reset();
    rst_n      = 1'b0;
    adc_cmd_in = 8'h00;
    adc_valid  = 1'b0;
    adc_data   = '0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    checks++;
    if (status_out !== 8'h00) $display("[TB] FAIL reset_status: got %h expected 00", status_out);
    else passed++;
    checks++;
    if ({adc_req, scan_done, adc_chan} !== 5'b0)
      $display("[TB] FAIL reset_ctrl: got req=%b done=%b chan=%0d expected 0/0/0", adc_req, scan_done, adc_chan);
    else passed++;
    checks++;
    if (any_result_nonzero() !== 1'b0) $display("[TB] FAIL reset_results: got nonzero expected all zero");
    else passed++;
  endtask

  task automatic test_single();
    int r0;
    r0 = req_total;
    adc_cmd_in = 8'h05;
    tick(2);
    checks++;
    if (adc_req !== 1'b0) $display("[TB] FAIL single_req_early: got %b expected 0", adc_req);
    else passed++;
    tick(1);
    checks++;
    if (adc_req !== 1'b1 || adc_chan !== 3'd0)
      $display("[TB] FAIL single_req: got req=%b chan=%0d expected 1/0", adc_req, adc_chan);
    else passed++;
    respond(12'hABC);
    checks++;
    if (up_o[0] !== 8'h00) $display("[TB] FAIL single_store_early: got %h expected 00", up_o[0]);
    else passed++;
    tick(1);
    checks++;
    if (up_o[0] !== 8'h0A || lo_o[0] !== 8'hBC)
      $display("[TB] FAIL single_data: got %h/%h expected 0A/BC", up_o[0], lo_o[0]);
    else passed++;
    tick(1);
    checks++;
    if (scan_done !== 1'b1 || status_out !== 8'h01)
      $display("[TB] FAIL single_done: got done=%b status=%h expected 1/01", scan_done, status_out);
    else passed++;
    tick(1);
    checks++;
    if (scan_done !== 1'b0 || status_out !== 8'h01)
      $display("[TB] FAIL single_after: got done=%b status=%h expected 0/01", scan_done, status_out);
    else passed++;
    tick(5);
    checks++;
    if (req_total - r0 !== 1) $display("[TB] FAIL single_req_count: got %0d expected 1", req_total - r0);
    else passed++;
  endtask

  task automatic test_all_channels();
    bit ok;
    int cyc;
    int r0;
    adc_cmd_in = 8'h00;
    tick(1);
    r0 = req_total;
    adc_cmd_in = 8'hFD;
    for (int n = 0; n < 6; n++) begin
      wait_req(20, ok, cyc);
      checks++;
      if (!ok || adc_chan !== 3'(n))
        $display("[TB] FAIL all_req_order: got ok=%b chan=%0d expected 1/%0d", ok, adc_chan, n);
      else passed++;
      respond(12'(n * 256 + n));
    end
    wait_done(10, ok, cyc);
    checks++;
    if (!ok || status_out !== 8'h16)
      $display("[TB] FAIL all_status: got ok=%b status=%h expected 1/16", ok, status_out);
    else passed++;
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (up_o[n] !== 8'(n) || lo_o[n] !== 8'(n))
        $display("[TB] FAIL all_data ch%0d: got %h/%h expected %h/%h", n, up_o[n], lo_o[n], 8'(n), 8'(n));
      else passed++;
    end
    tick(3);
    checks++;
    if (req_total - r0 !== 6) $display("[TB] FAIL all_req_count: got %0d expected 6", req_total - r0);
    else passed++;
  endtask

  task automatic test_timeout();
    bit ok;
    int cyc;
    int r0;
    adc_cmd_in = 8'h00;
    tick(1);
    adc_cmd_in = 8'h0D;
    wait_req(10, ok, cyc);
    checks++;
    if (!ok || adc_chan !== 3'd0) $display("[TB] FAIL tmo_first_req: got ok=%b chan=%0d expected 1/0", ok, adc_chan);
    else passed++;
    // 1024 WAIT cycles, then SELECT and REQ before the next request shows.
    wait_req(TMO + 10, ok, cyc);
    checks++;
    if (!ok || cyc !== TMO + 2 || adc_chan !== 3'd1)
      $display("[TB] FAIL tmo_length: got ok=%b cycles=%0d chan=%0d expected 1/%0d/1", ok, cyc, adc_chan, TMO + 2);
    else passed++;
    checks++;
    if (status_out[6] !== 1'b1) $display("[TB] FAIL tmo_err_set: got %b expected 1", status_out[6]);
    else passed++;
    checks++;
    if (up_o[0] !== 8'h00 || lo_o[0] !== 8'h00)
      $display("[TB] FAIL tmo_ch0_kept: got %h/%h expected 00/00", up_o[0], lo_o[0]);
    else passed++;
    respond(12'h3C5);
    wait_done(10, ok, cyc);
    checks++;
    if (!ok || status_out !== 8'h47)
      $display("[TB] FAIL tmo_status: got ok=%b status=%h expected 1/47", ok, status_out);
    else passed++;
    checks++;
    if (up_o[1] !== 8'h03 || lo_o[1] !== 8'hC5)
      $display("[TB] FAIL tmo_ch1_data: got %h/%h expected 03/C5", up_o[1], lo_o[1]);
    else passed++;
    // Empty pass: a new START edge with no channels clears the error and
    // wraps the pass count from 3 to 0 without any request.
    adc_cmd_in = 8'h00;
    tick(1);
    r0 = req_total;
    adc_cmd_in = 8'h01;
    tick(1);
    checks++;
    if (status_out !== 8'h87) $display("[TB] FAIL empty_select: got %h expected 87", status_out);
    else passed++;
    tick(1);
    checks++;
    if (scan_done !== 1'b1 || status_out !== 8'h04)
      $display("[TB] FAIL empty_done: got done=%b status=%h expected 1/04", scan_done, status_out);
    else passed++;
    tick(5);
    checks++;
    if (req_total - r0 !== 0) $display("[TB] FAIL empty_no_req: got %0d expected 0", req_total - r0);
    else passed++;
  endtask

  task automatic test_auto();
    bit ok;
    int cyc;
    int r0;
    adc_cmd_in = 8'h00;
    tick(1);
    adc_cmd_in = 8'h06;
    for (int p = 1; p <= 4; p++) begin
      wait_req(GAP + 20, ok, cyc);
      checks++;
      if (!ok || cyc !== ((p == 1) ? 3 : GAP + 2))
        $display("[TB] FAIL auto_spacing pass%0d: got ok=%b cycles=%0d expected 1/%0d", p, ok, cyc, (p == 1) ? 3 : GAP + 2);
      else passed++;
      respond(12'(p));
      wait_done(10, ok, cyc);
      checks++;
      if (!ok || status_out !== (8'h20 | 8'(p % 4)))
        $display("[TB] FAIL auto_status pass%0d: got ok=%b status=%h expected 1/%h", p, ok, status_out, 8'h20 | 8'(p % 4));
      else passed++;
    end
    adc_cmd_in = 8'h04;
    tick(1);
    checks++;
    if (status_out !== 8'h00) $display("[TB] FAIL auto_stop: got %h expected 00", status_out);
    else passed++;
    r0 = req_total;
    tick(GAP + 10);
    checks++;
    if (req_total - r0 !== 0) $display("[TB] FAIL auto_stop_no_req: got %0d expected 0", req_total - r0);
    else passed++;
  endtask

  task automatic test_reset_abort();
    bit ok;
    int cyc;
    int r0;
    adc_cmd_in = 8'h00;
    tick(1);
    adc_cmd_in = 8'h05;
    wait_req(10, ok, cyc);
    checks++;
    if (!ok) $display("[TB] FAIL abort_req: got no request expected request");
    else passed++;
    rst_n      = 1'b0;
    adc_cmd_in = 8'h00;
    #1;
    checks++;
    if (status_out !== 8'h00 || adc_req !== 1'b0 || any_result_nonzero() !== 1'b0)
      $display("[TB] FAIL abort_immediate: got status=%h req=%b expected 00/0", status_out, adc_req);
    else passed++;
    tick(2);
    rst_n = 1'b1;
    r0 = req_total;
    tick(1);
    respond(12'hFFF);
    tick(5);
    checks++;
    if (status_out !== 8'h00 || any_result_nonzero() !== 1'b0 || scan_done !== 1'b0 || adc_chan !== 3'd0)
      $display("[TB] FAIL abort_late_valid: got status=%h chan=%0d expected 00/0 and zero results", status_out, adc_chan);
    else passed++;
    checks++;
    if (req_total - r0 !== 0) $display("[TB] FAIL abort_no_req: got %0d expected 0", req_total - r0);
    else passed++;
  endtask

  task automatic test_spurious_and_mask();
    bit ok;
    int cyc;
    int r0;
    r0 = req_total;
    adc_cmd_in = 8'h05;
    wait_req(10, ok, cyc);
    checks++;
    if (!ok || adc_chan !== 3'd0) $display("[TB] FAIL mask_req: got ok=%b chan=%0d expected 1/0", ok, adc_chan);
    else passed++;
    adc_cmd_in = 8'h0D;
    respond(12'h123);
    wait_done(10, ok, cyc);
    checks++;
    if (!ok || status_out !== 8'h01)
      $display("[TB] FAIL mask_status: got ok=%b status=%h expected 1/01", ok, status_out);
    else passed++;
    tick(3);
    respond(12'h456);
    tick(3);
    checks++;
    if (up_o[0] !== 8'h01 || lo_o[0] !== 8'h23)
      $display("[TB] FAIL spurious_valid: got %h/%h expected 01/23", up_o[0], lo_o[0]);
    else passed++;
    checks++;
    if (up_o[1] !== 8'h00 || lo_o[1] !== 8'h00 || req_total - r0 !== 1)
      $display("[TB] FAIL mask_ignored: got ch1=%h/%h reqs=%0d expected 00/00/1", up_o[1], lo_o[1], req_total - r0);
    else passed++;
    checks++;
    if (status_out !== 8'h01) $display("[TB] FAIL spurious_status: got %h expected 01", status_out);
    else passed++;
  endtask

  initial begin
    $display("[TB] adc_scan_controller directed tests");
    test_reset();
    test_single();
    test_all_channels();
    test_timeout();
    test_auto();
    test_reset_abort();
    test_spurious_and_mask();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
